// File: rtl/cpu_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cpu_defs (package)                                              |
// | Brief  : Shared fetch-stage encodings and instruction-set constants.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package cpu_defs;
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_VALID = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int unsigned WORD_BYTES = 4;
endpackage
`default_nettype wire

// File: rtl/instr_fetch_npc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : npc                                                             |
// | Brief  : Combinational next-PC: sequential, taken branch or jump.        |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module npc
    import cpu_defs::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] NextPC
);
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;

    assign w_pc4     = PC + 32'(WORD_BYTES);
    assign w_br_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    assign w_jmp_tgt = {w_pc4[31:28], Instr[25:0], 2'b00};

    // Jump outranks a taken branch.
    always_comb begin
        NextPC = w_pc4;
        if (Jump) begin
            NextPC = w_jmp_tgt;
        end else if (Branch && Zero) begin
            NextPC = w_pc4 + w_br_off;
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : instr_fetch                                                     |
// | Brief  : PC/IR fetch stage with req/ack memory handshake and retire.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module instr_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  Func,
    output logic        InstrValid,
    output logic [31:0] PC,
    input  logic        Retire,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic        RetireErr,
    output logic [31:0] RetireCnt
);
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [31:0]          r_pc;
    logic [31:0]          r_ir;
    logic                 r_err;
    logic [31:0]          r_cnt;
    logic [31:0]          w_next_pc;
    logic                 w_take_ack;
    logic                 w_take_retire;

    npc u_npc (
        .PC     (r_pc),
        .Instr  (r_ir),
        .Branch (Branch),
        .Zero   (Zero),
        .Jump   (Jump),
        .NextPC (w_next_pc)
    );

    assign w_take_ack    = (r_state == c_ST_FETCH) && ImemAck;
    assign w_take_retire = (r_state == c_ST_VALID) && Retire;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = c_ST_FETCH;
            c_ST_FETCH: if (ImemAck) w_state_nxt = c_ST_VALID;
            c_ST_VALID: if (Retire)  w_state_nxt = c_ST_FETCH;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_ack) begin
                r_ir <= ImemData;
            end
            if (w_take_retire) begin
                r_pc  <= w_next_pc;
                r_cnt <= r_cnt + 32'd1;
            end
            // Retire with nothing valid is a protocol error from Control.
            if (Retire && (r_state != c_ST_VALID)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ImemReq    = (r_state == c_ST_FETCH);
    assign ImemAddr   = r_pc;
    assign PC         = r_pc;
    assign Instr      = r_ir;
    assign OpCode     = r_ir[31:26];
    assign Func       = r_ir[5:0];
    assign InstrValid = (r_state == c_ST_VALID);
    assign RetireErr  = r_err;
    assign RetireCnt  = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_instr_fetch                                                  |
// | Brief  : Vector table, corner sequences and random run vs. a model.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic        retire = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;

    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_cnt;
    logic [5:0]  w_op, w_func;
    logic        w2_req, w2_valid, w2_err;
    logic [31:0] w2_addr, w2_instr, w2_pc, w2_cnt;
    logic [5:0]  w2_op, w2_func;

    int n_checks = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .ImemReq(w_req), .ImemAddr(w_addr),
        .ImemAck(ack), .ImemData(data), .Instr(w_instr), .OpCode(w_op),
        .Func(w_func), .InstrValid(w_valid), .PC(w_pc), .Retire(retire),
        .Branch(branch), .Zero(zero), .Jump(jump), .RetireErr(w_err),
        .RetireCnt(w_cnt)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ImemReq(w2_req), .ImemAddr(w2_addr),
        .ImemAck(ack), .ImemData(data), .Instr(w2_instr), .OpCode(w2_op),
        .Func(w2_func), .InstrValid(w2_valid), .PC(w2_pc), .Retire(retire),
        .Branch(branch), .Zero(zero), .Jump(jump), .RetireErr(w2_err),
        .RetireCnt(w2_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        b, z, j;
        int          wait_cyc;
        logic [31:0] next;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int k = 0;
        while (!w_req && k < 20) begin
            tick();
            k++;
        end
        check("req_wait", 32'(w_req), 32'd1);
    endtask

    // Reference next-PC from plain arithmetic on the instruction fields.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic b, input logic z, input logic j);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) + ((ir & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            off = int'(ir & 32'h0000_FFFF);
            if (off >= 32768) off = off - 65536;
            return pc4 + 32'(off * 4);
        end
        return pc4;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ack = 1'b0; retire = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Random-phase model state
    bit          m_start, m_fetch, m_valid, m_err;
    logic [31:0] m_pc, m_ir, m_cnt;

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 3, 32'h0000_0004};
        tbl[1] = '{32'h0000_0004, 32'h1000_0001, 1'b1, 1'b1, 1'b0, 0, 32'h0000_000C};
        tbl[2] = '{32'h0000_000C, 32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1, 32'h0000_000C};
        tbl[3] = '{32'h0000_000C, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 2, 32'h0000_0010};
        tbl[4] = '{32'h0000_0010, 32'h0800_0C00, 1'b0, 1'b0, 1'b1, 0, 32'h0000_3000};
        tbl[5] = '{32'h0000_3000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 1, 32'h0000_0100};
        tbl[6] = '{32'h0000_0100, 32'h1000_FFF0, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0104};
        tbl[7] = '{32'h0000_0104, 32'h1000_FFF0, 1'b1, 1'b1, 1'b0, 2, 32'h0000_00C8};

        do_reset();
        check("rst_req", 32'(w_req), 32'd0);
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_instr", w_instr, 32'd0);
        check("rst_err", 32'(w_err), 32'd0);
        check("rst_cnt", w_cnt, 32'd0);
        check("rst_pc", w_pc, 32'd0);
        tick();
        check("first_req", 32'(w_req), 32'd1);

        for (int i = 0; i < 8; i++) begin
            wait_req();
            check("tbl_addr", w_addr, tbl[i].addr);
            for (int w = 0; w < tbl[i].wait_cyc; w++) begin
                tick();
                check("tbl_wait_valid", 32'(w_valid), 32'd0);
            end
            ack = 1'b1; data = tbl[i].instr;
            tick();
            ack = 1'b0; data = 32'hA5A5_A5A5;
            check("tbl_valid", 32'(w_valid), 32'd1);
            check("tbl_req_low", 32'(w_req), 32'd0);
            check("tbl_instr", w_instr, tbl[i].instr);
            check("tbl_opcode", 32'(w_op), tbl[i].instr >> 26);
            check("tbl_func", 32'(w_func), tbl[i].instr & 32'h3F);
            branch = tbl[i].b; zero = tbl[i].z; jump = tbl[i].j; retire = 1'b1;
            tick();
            retire = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
            check("tbl_next_req", 32'(w_req), 32'd1);
            check("tbl_next_addr", w_addr, tbl[i].next);
            check("tbl_cnt", w_cnt, 32'(i + 1));
            check("tbl_valid_drop", 32'(w_valid), 32'd0);
        end
        check("tbl_no_err", 32'(w_err), 32'd0);

        // Retire while fetching: sticky error, no PC/count change.
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check("fetch_retire_err", 32'(w_err), 32'd1);
        check("fetch_retire_pc", w_pc, 32'h0000_00C8);
        check("fetch_retire_cnt", w_cnt, 32'd8);
        check("fetch_retire_req", 32'(w_req), 32'd1);

        // Stray ack while VALID leaves IR alone.
        ack = 1'b1; data = 32'h1234_5678;
        tick();
        data = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        check("stray_ack_instr", w_instr, 32'h1234_5678);
        check("stray_ack_valid", 32'(w_valid), 32'd1);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check("post_stray_addr", w_addr, 32'h0000_00CC);

        // Reset mid-FETCH, then wrap check on the high-reset instance.
        rst_n = 1'b0;
        tick();
        check("midrst_req", 32'(w_req), 32'd0);
        check("midrst_valid", 32'(w_valid), 32'd0);
        check("midrst_pc", w_pc, 32'd0);
        check("midrst_err", 32'(w_err), 32'd0);
        check("midrst_cnt", w_cnt, 32'd0);
        rst_n = 1'b1;
        check("midrst_idle_req", 32'(w_req), 32'd0);
        tick();
        check("refetch_req", 32'(w_req), 32'd1);
        check("refetch_addr", w_addr, 32'd0);
        check("wrap_start_addr", w2_addr, 32'hFFFF_FFFC);
        ack = 1'b1; data = 32'h0000_0020;
        tick();
        ack = 1'b0;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check("wrap_addr", w2_addr, 32'h0000_0000);
        check("wrap_req", 32'(w2_req), 32'd1);
        check("wrap_err", 32'(w2_err), 32'd0);
        check("seq_addr", w_addr, 32'h0000_0004);

        // Random run against the reference model.
        do_reset();
        m_start = 1'b1; m_fetch = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_pc = 32'd0; m_ir = 32'd0; m_cnt = 32'd0;
        for (int c = 0; c < 400; c++) begin
            ack    = ($urandom_range(0, 2) == 0);
            retire = ($urandom_range(0, 4) == 0);
            branch = 1'($urandom_range(0, 1));
            zero   = 1'($urandom_range(0, 1));
            jump   = ($urandom_range(0, 3) == 0);
            data   = $urandom;
            tick();
            if (m_start) begin
                if (retire) m_err = 1'b1;
                m_start = 1'b0;
                m_fetch = 1'b1;
            end else if (m_fetch) begin
                if (retire) m_err = 1'b1;
                if (ack) begin
                    m_ir = data;
                    m_fetch = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (retire) begin
                m_pc = ref_npc(m_pc, m_ir, branch, zero, jump);
                m_cnt = m_cnt + 32'd1;
                m_valid = 1'b0;
                m_fetch = 1'b1;
            end
            check("rnd_req", 32'(w_req), 32'(m_fetch));
            check("rnd_valid", 32'(w_valid), 32'(m_valid));
            check("rnd_addr", w_addr, m_pc);
            check("rnd_instr", w_instr, m_ir);
            check("rnd_err", 32'(w_err), 32'(m_err));
            check("rnd_cnt", w_cnt, m_cnt);
        end
        ack = 1'b0; retire = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
